// File: rtl/booth_div_seq_if.sv
// Start/ready handshake and operand/result bundle for the sequential divider.
// The slave modport is the divider; the master modport is whoever issues divisions.
interface booth_div_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             ready;
    logic             busy;
    logic             div_by_zero;

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, ready, busy, div_by_zero
    );

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, ready, busy, div_by_zero
    );
endinterface

// File: rtl/booth_div_seq.sv
// Sequential radix-2 restoring divider, one quotient bit per clock.
// Define SIGNED_DIV_EN for two's-complement operands (adds the FIX sign-correction state).
module booth_div_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    booth_div_seq_if.slave  bus
);

`ifdef SIGNED_DIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    // Partial remainder is always below the divisor, so WIDTH bits are enough.
    logic [WIDTH-1:0]   r_q, r_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               dbz_q, dbz_d;
    logic               zero_pend_q, zero_pend_d;
`ifdef SIGNED_DIV_EN
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
`endif

    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   r_next_s;
    logic [WIDTH-1:0]   q_next_s;

`ifdef SIGNED_DIV_EN
    function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? neg2(v) : v;
    endfunction
`endif

    // One restoring step: trial-subtract the divisor from the shifted remainder.
    always_comb begin
        shifted_s = {r_q, q_q[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, d_q};
        if (diff_s[WIDTH] == 1'b0) begin
            r_next_s = diff_s[WIDTH-1:0];
            q_next_s = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            r_next_s = shifted_s[WIDTH-1:0];
            q_next_s = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        dbz_d       = dbz_q;
        zero_pend_d = zero_pend_q;
`ifdef SIGNED_DIV_EN
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // A zero divisor publishes its result one edge after acceptance.
                if (state_q == DONE && zero_pend_q) begin
                    quo_d       = {WIDTH{1'b1}};
                    rem_d       = q_q;
                    dbz_d       = 1'b1;
                    ready_d     = 1'b1;
                    zero_pend_d = 1'b0;
                end else begin
                    zero_pend_d = zero_pend_q;
                end
                if (bus.start) begin
                    count_d = {CNT_W{1'b0}};
                    ready_d = 1'b0;
                    dbz_d   = 1'b0;
                    r_d     = {WIDTH{1'b0}};
                    if (bus.divisor == {WIDTH{1'b0}}) begin
                        state_d     = DONE;
                        q_d         = bus.dividend;
                        zero_pend_d = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        state_d     = CALC;
                        busy_d      = 1'b1;
                        zero_pend_d = 1'b0;
`ifdef SIGNED_DIV_EN
                        q_d         = mag(bus.dividend);
                        d_d         = mag(bus.divisor);
                        neg_quo_d   = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        neg_rem_d   = bus.dividend[WIDTH-1];
`else
                        q_d         = bus.dividend;
                        d_d         = bus.divisor;
`endif
                    end
                end else begin
                    state_d = state_q;
                end
            end
            CALC: begin
                r_d     = r_next_s;
                q_d     = q_next_s;
                count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (count_q == CNT_W'(WIDTH - 1)) begin
`ifdef SIGNED_DIV_EN
                    state_d = FIX;
`else
                    state_d = DONE;
                    quo_d   = q_next_s;
                    rem_d   = r_next_s;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
`endif
                end else begin
                    state_d = CALC;
                end
            end
`ifdef SIGNED_DIV_EN
            FIX: begin
                quo_d   = neg_quo_q ? neg2(q_q) : q_q;
                rem_d   = neg_rem_q ? neg2(r_q) : r_q;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
`endif
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= {CNT_W{1'b0}};
            r_q         <= {WIDTH{1'b0}};
            q_q         <= {WIDTH{1'b0}};
            d_q         <= {WIDTH{1'b0}};
            quo_q       <= {WIDTH{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            dbz_q       <= 1'b0;
            zero_pend_q <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            dbz_q       <= dbz_d;
            zero_pend_q <= zero_pend_d;
`ifdef SIGNED_DIV_EN
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.ready       = ready_q;
    assign bus.busy        = busy_q;
    assign bus.div_by_zero = dbz_q;

endmodule
